// File: rtl/md_hilo.sv
// HI/LO register pair and start/wait sequencer behind the divider and multiplier.
// Captures the selected unit's result after its fixed latency; services mthi/mtlo.
module md_hilo #(
  parameter int DIV_WAIT  = 2,
  parameter int MULT_WAIT = 33
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_div,
  input  logic        start_mult,
  input  logic [31:0] div_lo,
  input  logic [31:0] div_hi,
  input  logic        div0,
  input  logic [31:0] mult_lo,
  input  logic [31:0] mult_hi,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DIV  = 2'd1,
    WAIT_MULT = 2'd2
  } state_e;

  localparam logic [5:0] DIV_LOAD  = 6'(DIV_WAIT - 1);
  localparam logic [5:0] MULT_LOAD = 6'(MULT_WAIT - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;

  // State, counter, HI/LO and status flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
    end
  end

  // Next state and latency counter; starts outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_div) begin
          state_d = WAIT_DIV;
          cnt_d   = DIV_LOAD;
        end else if (start_mult) begin
          state_d = WAIT_MULT;
          cnt_d   = MULT_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      WAIT_DIV: begin
        if (div0 || (cnt_q == 6'd0)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      WAIT_MULT: begin
        if (cnt_q == 6'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Register writes, capture and one-cycle status pulses
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    exc_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mthi) begin
          hi_d = wdata;
        end else begin
          hi_d = hi_q;
        end
        if (mtlo) begin
          lo_d = wdata;
        end else begin
          lo_d = lo_q;
        end
      end
      WAIT_DIV: begin
        if (div0) begin
          exc_d = 1'b1;
        end else if (cnt_q == 6'd0) begin
          hi_d   = div_hi;
          lo_d   = div_lo;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      WAIT_MULT: begin
        if (cnt_q == 6'd0) begin
          hi_d   = mult_hi;
          lo_d   = mult_lo;
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
        exc_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div0_exc = exc_q;

endmodule

// File: tb/tb_md_hilo.sv
// Scoreboard bench for md_hilo: directed cases from the plan plus random traffic,
// checked against an edge-indexed reference model of the sequencer.
module tb_md_hilo;
  localparam int DIV_WAIT  = 2;
  localparam int MULT_WAIT = 33;

  logic        clock, reset, start_div, start_mult, div0, mthi, mtlo;
  logic [31:0] div_lo, div_hi, mult_lo, mult_hi, wdata, hi_out, lo_out;
  logic        busy, done, div0_exc;
  logic [31:0] op_a, op_b;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int cyc; logic is_exc; logic [31:0] hi; logic [31:0] lo; } ev_t;
  typedef struct { int cyc; logic busy; logic [31:0] hi; logic [31:0] lo; } cy_t;
  ev_t evq[$];
  cy_t cq[$];

  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  int          m_end = -1;

  md_hilo #(.DIV_WAIT(DIV_WAIT), .MULT_WAIT(MULT_WAIT)) dut (
    .clock(clock), .reset(reset), .start_div(start_div), .start_mult(start_mult),
    .div_lo(div_lo), .div_hi(div_hi), .div0(div0), .mult_lo(mult_lo), .mult_hi(mult_hi),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div0_exc(div0_exc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-ins for the divider and multiplier; their outputs hold while operands hold.
  always_comb begin
    div0 = (op_b == 32'd0);
    if (op_b != 32'd0) begin
      div_lo = op_a / op_b;
      div_hi = op_a % op_b;
    end else begin
      div_lo = 32'hBAD0_BAD0;
      div_hi = 32'h0BAD_0BAD;
    end
    {mult_hi, mult_lo} = {32'd0, op_a} * {32'd0, op_b};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    op_a = a;
    op_b = b;
  endtask

  // Drive one edge's worth of inputs, predict what that edge does, wait for the next negedge.
  task automatic step(input logic sd, input logic sm, input logic wh, input logic wl,
                      input logic [31:0] wd);
    int          k;
    ev_t         e;
    cy_t         c;
    logic [63:0] p;
    start_div  = sd;
    start_mult = sm;
    mthi       = wh;
    mtlo       = wl;
    wdata      = wd;
    k = cyc + 1;
    if (k > m_end) begin
      if (wh) m_hi = wd;
      if (wl) m_lo = wd;
      if (sd) begin
        if (op_b == 32'd0) begin
          m_end = k + 1;
          e.is_exc = 1'b1;
        end else begin
          m_end = k + DIV_WAIT;
          m_lo = op_a / op_b;
          m_hi = op_a % op_b;
          e.is_exc = 1'b0;
        end
        e.cyc = m_end; e.hi = m_hi; e.lo = m_lo;
        evq.push_back(e);
      end else if (sm) begin
        m_end = k + MULT_WAIT;
        p = 64'(op_a) * 64'(op_b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.cyc = m_end; e.is_exc = 1'b0; e.hi = m_hi; e.lo = m_lo;
        evq.push_back(e);
      end
    end
    c.cyc = k; c.busy = (k < m_end); c.hi = m_hi; c.lo = m_lo;
    cq.push_back(c);
    @(negedge clock);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hi"}, hi_out, 32'd0);
    check({tag, "_lo"}, lo_out, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_exc"}, {31'd0, div0_exc}, 32'd0);
  endtask

  // Called just after a negedge: asserts reset mid-cycle and checks the asynchronous clear.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_all_zero(tag);
    start_div = 1'b0; start_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    evq.delete();
    cq.delete();
    m_hi = 32'd0; m_lo = 32'd0; m_end = cyc;
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
  endtask

  // Monitor: matches done/div0_exc pulses and per-edge busy/HI/LO against the scoreboard.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL missing_event: actual=none required=%s at cycle %0d",
                 evq[0].is_exc ? "div0_exc" : "done", evq[0].cyc);
        void'(evq.pop_front());
      end
      if (done || div0_exc) begin
        if (evq.size() == 0 || evq[0].cyc != cyc) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_event: actual done=%0b div0_exc=%0b required=none (cycle %0d)",
                   done, div0_exc, cyc);
        end else begin
          ev_t e;
          e = evq.pop_front();
          check("event_kind", {30'd0, done, div0_exc}, e.is_exc ? 32'd1 : 32'd2);
          check("event_hi", hi_out, e.hi);
          check("event_lo", lo_out, e.lo);
        end
      end
      while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        cy_t c;
        c = cq.pop_front();
        check("busy", {31'd0, busy}, {31'd0, c.busy});
        if (!c.busy) begin
          check("hi_out", hi_out, c.hi);
          check("lo_out", lo_out, c.lo);
        end
      end
    end
  end

  initial begin
    int e0;
    logic sd, sm;
    reset = 1'b1; start_div = 1'b0; start_mult = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wdata = 32'd0;
    set_ops(32'd0, 32'd1);
    #1 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);

    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    check("mthi_hi", hi_out, 32'hDEAD_BEEF);
    idle_steps(1);

    set_ops(32'd7, 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("div_busy_e0", {31'd0, busy}, 32'd1);
    idle_steps(1);
    check("div_busy_e1", {31'd0, busy}, 32'd1);
    check("div_no_early_done", {31'd0, done}, 32'd0);
    idle_steps(1);
    check("div_lo", lo_out, 32'd3);
    check("div_hi", hi_out, 32'd1);
    check("div_done", {31'd0, done}, 32'd1);
    check("div_busy_after", {31'd0, busy}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_single", {31'd0, done}, 32'd0);
    idle_steps(3);

    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
    set_ops(32'd5, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("div0_exc_not_yet", {31'd0, div0_exc}, 32'd0);
    idle_steps(1);
    check("div0_exc", {31'd0, div0_exc}, 32'd1);
    check("div0_no_done", {31'd0, done}, 32'd0);
    check("div0_hi_kept", hi_out, 32'h11);
    check("div0_lo_kept", lo_out, 32'h22);
    idle_steps(1);
    check("div0_exc_single", {31'd0, div0_exc}, 32'd0);

    set_ops(32'hFFFF_FFFF, 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    e0 = cyc;
    idle_steps(4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd5);
    check("mult_ignores_start", {31'd0, busy}, 32'd1);
    check("mtlo_busy_ignored", lo_out, 32'h22);
    for (int i = 0; i < 40 && cyc < e0 + MULT_WAIT; i++) idle_steps(1);
    check("mult_hi", hi_out, 32'd1);
    check("mult_lo", lo_out, 32'hFFFF_FFFE);
    check("mult_done", {31'd0, done}, 32'd1);
    idle_steps(2);

    async_reset("midcycle_reset");

    set_ops(32'd9, 32'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    idle_steps(1);
    async_reset("reset_in_div");
    set_ops(32'd100, 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    idle_steps(2);
    check("post_reset_div_lo", lo_out, 32'd14);
    check("post_reset_div_hi", hi_out, 32'd2);
    check("post_reset_div_done", {31'd0, done}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      if (cyc + 1 > m_end) begin
        if ($urandom_range(0, 2) == 0)
          set_ops($urandom(), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)));
        sd = ($urandom_range(0, 4) == 0);
        sm = ($urandom_range(0, 5) == 0);
      end else begin
        sd = ($urandom_range(0, 7) == 0);
        sm = ($urandom_range(0, 7) == 0);
      end
      step(sd, sm, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom());
    end
    for (int i = 0; i < 40 && cyc <= m_end + 1; i++) idle_steps(1);
    idle_steps(2);

    while (evq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL missing_event_at_end: actual=none required event at cycle %0d", evq[0].cyc);
      void'(evq.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
